// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD converter.
// The converter side uses the slave modport; the requester/display side uses master.
interface bin_to_bcd_seq_if #(
    parameter int IN_W = 14
);
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic [15:0]     bcd_out;
    logic [3:0]      blank;
    logic            ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, blank, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, blank, ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with saturation at 9999 and
// leading-zero blanking; results are registered and held between conversions.
module bin_to_bcd_seq #(
    parameter int IN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int                CNT_W   = $clog2(IN_W + 1);
    localparam int                MAX_DEC = 9999;
    localparam logic [IN_W-1:0]   SAT_VAL = IN_W'(MAX_DEC);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_reg, state_next;

    logic [15:0]      scratch_reg;
    logic [IN_W-1:0]  bin_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_pending_reg;
    logic [15:0]      bcd_reg;
    logic [3:0]       blank_reg;
    logic             ovf_reg;
    logic             done_reg;

    logic             accept;
    logic             finish;
    logic [15:0]      adj;
    logic [15+IN_W:0] shifted;
    logic [3:0]       blank_next;

    // Per-nibble correction: no carry crosses nibble boundaries.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                  ? scratch_reg[gi*4 +: 4] + 4'd3
                                  : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {adj, bin_reg} << 1;

    assign blank_next[3] = (scratch_reg[15:12] == 4'd0);
    assign blank_next[2] = blank_next[3] & (scratch_reg[11:8] == 4'd0);
    assign blank_next[1] = blank_next[2] & (scratch_reg[7:4] == 4'd0);
    assign blank_next[0] = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Counter reaching zero means all IN_W bits have been shifted in.
                if (cnt_reg == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch_reg     <= 16'h0000;
            bin_reg         <= '0;
            cnt_reg         <= '0;
            ovf_pending_reg <= 1'b0;
            bcd_reg         <= 16'h0000;
            blank_reg       <= 4'b1110;
            ovf_reg         <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= finish;
            if (accept) begin
                scratch_reg <= 16'h0000;
                cnt_reg     <= CNT_W'(IN_W);
                if (32'(bus.bin_in) > MAX_DEC) begin
                    bin_reg         <= SAT_VAL;
                    ovf_pending_reg <= 1'b1;
                end else begin
                    bin_reg         <= bus.bin_in;
                    ovf_pending_reg <= 1'b0;
                end
            end else if (state_reg == SHIFT && !finish) begin
                scratch_reg <= shifted[15+IN_W:IN_W];
                bin_reg     <= shifted[IN_W-1:0];
                cnt_reg     <= cnt_reg - 1'b1;
            end
            if (finish) begin
                bcd_reg   <= scratch_reg;
                blank_reg <= blank_next;
                ovf_reg   <= ovf_pending_reg;
            end
        end
    end

    assign bus.busy    = (state_reg == SHIFT);
    assign bus.done    = done_reg;
    assign bus.bcd_out = bcd_reg;
    assign bus.blank   = blank_reg;
    assign bus.ovf     = ovf_reg;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes hand-computed results,
// a monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;
    localparam int IN_W = 14;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   exp_total = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    bin_to_bcd_seq_if #(.IN_W(IN_W)) bus ();

    bin_to_bcd_seq #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive a start request; when now=1 the caller is already at a negedge.
    task automatic issue(input logic [13:0] v, input exp_t e, input bit push, input bit now);
        if (!now) @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = v;
        if (push) begin
            exp_q.push_back(e);
            exp_total++;
        end
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        accept_cyc = cyc;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        $display("issue bin_in=%0d at cycle %0d", v, accept_cyc);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("done bcd=%04h blank=%04b ovf=%0b latency=%0d",
                             bus.bcd_out, bus.blank, bus.ovf, cyc - accept_cyc);
                    chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
                    chk("blank",   32'(bus.blank),   32'(e.blank));
                    chk("ovf",     32'(bus.ovf),     32'(e.ovf));
                    chk("busy_in_done", 32'(bus.busy), 32'd0);
                    chk("latency", 32'(cyc - accept_cyc), 32'(IN_W + 1));
                    @(negedge clk);
                    chk("done_one_cycle", 32'(bus.done), 32'd0);
                    chk("bcd_hold", 32'(bus.bcd_out), 32'(e.bcd));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bcd",   32'(bus.bcd_out), 32'h0000);
        chk("rst_blank", 32'(bus.blank),   32'b1110);
        chk("rst_ovf",   32'(bus.ovf),     32'd0);
        chk("rst_busy",  32'(bus.busy),    32'd0);
        chk("rst_done",  32'(bus.done),    32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        issue(14'd0, '{bcd: 16'h0000, blank: 4'b1110, ovf: 1'b0}, 1'b1, 1'b0);
        wait_done();
        issue(14'd255, '{bcd: 16'h0255, blank: 4'b1000, ovf: 1'b0}, 1'b1, 1'b0);
        wait_done();
        issue(14'd9999, '{bcd: 16'h9999, blank: 4'b0000, ovf: 1'b0}, 1'b1, 1'b0);
        wait_done();
        issue(14'd12345, '{bcd: 16'h9999, blank: 4'b0000, ovf: 1'b1}, 1'b1, 1'b0);
        wait_done();

        // Second start while busy must be ignored.
        issue(14'd1000, '{bcd: 16'h1000, blank: 4'b0000, ovf: 1'b0}, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'd42;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("ignored_start_done_count", 32'(done_cnt), 32'(exp_total));

        // Back-to-back: second start presented in the done cycle.
        issue(14'd7, '{bcd: 16'h0007, blank: 4'b1110, ovf: 1'b0}, 1'b1, 1'b0);
        wait_done();
        issue(14'd80, '{bcd: 16'h0080, blank: 4'b1100, ovf: 1'b0}, 1'b1, 1'b1);
        wait_done();

        // Reset mid-conversion aborts with no done pulse.
        issue(14'd4321, '{bcd: 16'h0000, blank: 4'b0000, ovf: 1'b0}, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_bcd",   32'(bus.bcd_out), 32'h0000);
        chk("abort_blank", 32'(bus.blank),   32'b1110);
        chk("abort_ovf",   32'(bus.ovf),     32'd0);
        chk("abort_busy",  32'(bus.busy),    32'd0);
        chk("abort_done",  32'(bus.done),    32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_done_count", 32'(done_cnt), 32'(exp_total));

        issue(14'd4321, '{bcd: 16'h4321, blank: 4'b0000, ovf: 1'b0}, 1'b1, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);

        chk("final_done_count", 32'(done_cnt), 32'(exp_total));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
